ras_ckpt: RTL and testbench

RAS_CKPT -- requirements
Module: ras_ckpt

---
 rtl/ras_ckpt.sv | 127 ++++++++++++
 tb/tb_ras_ckpt.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ras_ckpt.sv
// Return address stack with checkpoint save/restore.
// Circular stack; snapshots hold sp, count and top value.
//
// Ports:
//   clk, rst        : clock, async active-high reset
//   push, push_addr : predicted call and its return address
//   pop             : predicted return
//   ckpt_save/wid   : snapshot the pre-op state into slot wid
//   restore/rid     : recover from slot rid (has priority)
//   top_addr        : stack[sp-1] when count>0, else 0
//   count           : live entries, 0..DEPTH
//   empty, full     : count==0, count==DEPTH
//   restore_err     : 1-cycle pulse, restore of an invalid slot
module ras_ckpt #(
    parameter int DEPTH    = 16,
    parameter int AW       = 32,
    parameter int CKPT_NUM = 4,
    parameter int CW       = $clog2(CKPT_NUM)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [AW-1:0]          push_addr,
    input  logic                   ckpt_save,
    input  logic [CW-1:0]          ckpt_wid,
    input  logic                   restore,
    input  logic [CW-1:0]          ckpt_rid,
    output logic [AW-1:0]          top_addr,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full,
    output logic                   restore_err
);

    localparam int SW = $clog2(DEPTH);
    localparam logic [SW:0] FULL_CNT = (SW+1)'(DEPTH);

    logic [AW-1:0] stack [DEPTH];
    logic [SW-1:0] sp;
    logic [SW-1:0] sp_m1;
    logic [SW:0]   cnt;

    logic [CKPT_NUM-1:0] ck_vld;
    logic [SW-1:0]       ck_sp  [CKPT_NUM];
    logic [SW:0]         ck_cnt [CKPT_NUM];
    logic [AW-1:0]       ck_top [CKPT_NUM];

    logic          rs_ok;
    logic          rs_bad;
    logic [SW-1:0] sp_n;
    logic [SW:0]   cnt_n;
    logic          wr_en;
    logic [SW-1:0] wr_idx;
    logic [AW-1:0] wr_data;
    logic          err_q;

    assign sp_m1 = sp - 1'b1;
    assign rs_ok  = restore &  ck_vld[ckpt_rid];
    assign rs_bad = restore & ~ck_vld[ckpt_rid];

    assign top_addr    = (cnt != '0) ? stack[sp_m1] : '0;
    assign count       = cnt;
    assign empty       = (cnt == '0);
    assign full        = (cnt == FULL_CNT);
    assign restore_err = err_q;

    // Next-state: restore wins; an invalid restore also
    // suppresses push/pop so the stack is left untouched.
    always_comb begin
        sp_n    = sp;
        cnt_n   = cnt;
        wr_en   = 1'b0;
        wr_idx  = sp;
        wr_data = push_addr;
        if (restore) begin
            if (rs_ok) begin
                sp_n    = ck_sp[ckpt_rid];
                cnt_n   = ck_cnt[ckpt_rid];
                wr_en   = (ck_cnt[ckpt_rid] != '0);
                wr_idx  = ck_sp[ckpt_rid] - 1'b1;
                wr_data = ck_top[ckpt_rid];
            end
        end else if (push && (!pop || cnt == '0)) begin
            wr_en = 1'b1;
            sp_n  = sp + 1'b1;
            cnt_n = (cnt == FULL_CNT) ? cnt : cnt + 1'b1;
        end else if (push && pop) begin
            // call+return: replace the top in place
            wr_en  = 1'b1;
            wr_idx = sp_m1;
        end else if (pop && cnt != '0) begin
            sp_n  = sp_m1;
            cnt_n = cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp     <= '0;
            cnt    <= '0;
            ck_vld <= '0;
            err_q  <= 1'b0;
        end else begin
            sp    <= sp_n;
            cnt   <= cnt_n;
            err_q <= rs_bad;
            if (rs_ok)
                ck_vld[ckpt_rid] <= 1'b0;
            // a same-id save re-validates after the restore
            if (ckpt_save)
                ck_vld[ckpt_wid] <= 1'b1;
        end
    end

    // Payload storage is not reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_en)
            stack[wr_idx] <= wr_data;
        if (!rst && ckpt_save) begin
            ck_sp[ckpt_wid]  <= sp;
            ck_cnt[ckpt_wid] <= cnt;
            ck_top[ckpt_wid] <= stack[sp_m1];
        end
    end

endmodule

// File: tb/tb_ras_ckpt.sv
// Self-checking bench for ras_ckpt (DEPTH=4, CKPT_NUM=4).
// Directed scenarios, then random ops against a reference model.
module tb_ras_ckpt;

    localparam int D  = 4;
    localparam int N  = 4;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [AW-1:0] push_addr = '0;
    logic          ckpt_save = 1'b0;
    logic [1:0]    ckpt_wid = '0;
    logic          restore = 1'b0;
    logic [1:0]    ckpt_rid = '0;
    logic [AW-1:0] top_addr;
    logic [2:0]    count;
    logic          empty;
    logic          full;
    logic          restore_err;

    int n_chk = 0;
    int n_fail = 0;

    ras_ckpt #(.DEPTH(D), .AW(AW), .CKPT_NUM(N)) dut (
        .clk(clk), .rst(rst),
        .push(push), .pop(pop), .push_addr(push_addr),
        .ckpt_save(ckpt_save), .ckpt_wid(ckpt_wid),
        .restore(restore), .ckpt_rid(ckpt_rid),
        .top_addr(top_addr), .count(count),
        .empty(empty), .full(full),
        .restore_err(restore_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        int          sp;
        int          cnt;
        logic [31:0] top;
    } snap_t;

    logic [31:0] mem [D];
    int          m_sp;
    int          m_cnt;
    bit          m_err;
    snap_t       snap [N];

    function automatic int dec(input int x);
        return (x + D - 1) % D;
    endfunction

    function automatic logic [31:0] m_top();
        return (m_cnt > 0) ? mem[dec(m_sp)] : 32'h0;
    endfunction

    task automatic m_reset();
        m_sp = 0;
        m_cnt = 0;
        m_err = 0;
        for (int i = 0; i < N; i++) snap[i].v = 0;
    endtask

    task automatic m_step(input bit pu, input bit po,
                          input logic [31:0] a,
                          input bit sv, input int wid,
                          input bit rs, input int rid);
        snap_t old;
        snap_t nw;
        old = snap[rid];
        nw.v = 1;
        nw.sp = m_sp;
        nw.cnt = m_cnt;
        nw.top = mem[dec(m_sp)];
        m_err = 0;
        if (rs) begin
            if (old.v) begin
                snap[rid].v = 0;
                m_sp = old.sp;
                m_cnt = old.cnt;
                if (m_cnt > 0) mem[dec(m_sp)] = old.top;
            end else begin
                m_err = 1;
            end
        end else if (pu && (!po || m_cnt == 0)) begin
            mem[m_sp] = a;
            m_sp = (m_sp + 1) % D;
            if (m_cnt < D) m_cnt++;
        end else if (pu && po) begin
            mem[dec(m_sp)] = a;
        end else if (po && m_cnt > 0) begin
            m_sp = dec(m_sp);
            m_cnt--;
        end
        if (sv) snap[wid] = nw;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".top"}, 64'(top_addr), 64'(m_top()));
        chk({tag, ".count"}, 64'(count), 64'(m_cnt));
        chk({tag, ".empty"}, 64'(empty), 64'(m_cnt == 0));
        chk({tag, ".full"}, 64'(full), 64'(m_cnt == D));
        chk({tag, ".err"}, 64'(restore_err), 64'(m_err));
    endtask

    task automatic cyc(input string tag, input bit pu, input bit po,
                       input logic [31:0] a,
                       input bit sv, input int wid,
                       input bit rs, input int rid);
        push = pu;
        pop = po;
        push_addr = a;
        ckpt_save = sv;
        ckpt_wid = 2'(wid);
        restore = rs;
        ckpt_rid = 2'(rid);
        @(posedge clk);
        m_step(pu, po, a, sv, wid, rs, rid);
        #1;
        push = 0;
        pop = 0;
        ckpt_save = 0;
        restore = 0;
        chk_all(tag);
    endtask

    task automatic do_reset();
        rst = 1;
        m_reset();
        @(posedge clk);
        #1;
        rst = 0;
        chk_all("reset");
    endtask

    initial begin
        for (int i = 0; i < D; i++) mem[i] = '0;
        m_reset();
        @(posedge clk);
        do_reset();
        chk("reset.empty_k", 64'(empty), 64'd1);

        // push two, pop one
        cyc("p1", 1, 0, 32'h1C000010, 0, 0, 0, 0);
        cyc("p2", 1, 0, 32'h1C000020, 0, 0, 0, 0);
        chk("p2.top_k", 64'(top_addr), 64'h1C000020);
        cyc("pop1", 0, 1, 0, 0, 0, 0, 0);
        chk("pop1.top_k", 64'(top_addr), 64'h1C000010);

        // overflow: A1 lost
        do_reset();
        for (int i = 1; i <= 5; i++)
            cyc("ovf", 1, 0, 32'hA0 + 32'(i), 0, 0, 0, 0);
        chk("ovf.full_k", 64'(full), 64'd1);
        chk("ovf.top_k", 64'(top_addr), 64'hA5);
        for (int i = 0; i < 4; i++)
            cyc("drain", 0, 1, 0, 0, 0, 0, 0);
        chk("drain.top_k", 64'(top_addr), 64'h0);

        // pop empty, then push+pop on empty
        cyc("pop_empty", 0, 1, 0, 0, 0, 0, 0);
        cyc("pp_empty", 1, 1, 32'hBEEF0004, 0, 0, 0, 0);
        chk("pp_empty.top_k", 64'(top_addr), 64'hBEEF0004);

        // save / pop / push / restore / double restore
        do_reset();
        cyc("a", 1, 0, 32'hA, 0, 0, 0, 0);
        cyc("b", 1, 0, 32'hB, 0, 0, 0, 0);
        cyc("save2", 0, 0, 0, 1, 2, 0, 0);
        cyc("popb", 0, 1, 0, 0, 0, 0, 0);
        cyc("pushc", 1, 0, 32'hC, 0, 0, 0, 0);
        cyc("rs2", 0, 0, 0, 0, 0, 1, 2);
        chk("rs2.top_k", 64'(top_addr), 64'hB);
        cyc("rs2b", 0, 0, 0, 0, 0, 1, 2);
        chk("rs2b.err_k", 64'(restore_err), 64'd1);
        cyc("idle", 0, 0, 0, 0, 0, 0, 0);

        // same-id save+restore with push ignored
        do_reset();
        cyc("a1", 1, 0, 32'hA, 0, 0, 0, 0);
        cyc("sv1", 0, 0, 0, 1, 1, 0, 0);
        cyc("sr1", 1, 0, 32'hD, 1, 1, 1, 1);
        chk("sr1.top_k", 64'(top_addr), 64'hA);
        cyc("rs1", 0, 0, 0, 0, 0, 1, 1);
        chk("rs1.err_k", 64'(restore_err), 64'd0);

        // async reset between edges during a push
        cyc("pre", 1, 0, 32'h77, 1, 3, 0, 0);
        push = 1;
        push_addr = 32'h88;
        #2;
        rst = 1;
        m_reset();
        #1;
        chk("arst.count", 64'(count), 64'd0);
        chk("arst.empty", 64'(empty), 64'd1);
        #1;
        rst = 0;
        push = 0;
        cyc("arst_rs", 0, 0, 0, 0, 0, 1, 3);
        chk("arst_rs.err_k", 64'(restore_err), 64'd1);

        // random ops
        for (int i = 0; i < 400; i++) begin
            cyc("rnd",
                ($urandom_range(0, 9) < 5),
                ($urandom_range(0, 9) < 4),
                $urandom(),
                ($urandom_range(0, 9) < 2),
                int'($urandom_range(0, N - 1)),
                ($urandom_range(0, 19) < 3),
                int'($urandom_range(0, N - 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
